// File: rtl/chaos_sched_pkg.sv
// Shared types and constants for the chaos core step scheduler.
package chaos_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        SEED,
        LOAD,
        ARM,
        RUN,
        DELIVER,
        FAULT
    } sched_state_t;

    // Core SHIFT value presented after reset (1000.0 in IEEE-754 single).
    localparam logic [31:0] SHIFT_DEFAULT = 32'h447a0000;

    // Default number of RUN cycles allowed before CORE_DONE is considered lost.
    localparam int unsigned DONE_TMO_DEFAULT = 63;

endpackage

// File: rtl/chaos_step_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts after the last granted requester,
// pointer moves only when the owner strobes advance.
module rr_arbiter
    import chaos_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req,
    input  logic                        advance,
    output logic [NREQ-1:0]             grant_c,
    output logic [$clog2(NREQ)-1:0]     grant_idx_c
);

    localparam int unsigned IW = $clog2(NREQ);

    logic [IW-1:0] last;
    logic [IW-1:0] cand;
    logic          found;

    // Pick the first requester after the last one granted, wrapping at NREQ.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IW'((32'(last) + i) % NREQ);
            if (!found && req[cand]) begin
                found          = 1'b1;
                grant_c[cand]  = 1'b1;
                grant_idx_c    = cand;
            end
        end
    end

    // Pointer starts at NREQ-1 so requester 0 wins first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= IW'(NREQ - 1);
        end else if (advance && found) begin
            last <= grant_idx_c;
        end
    end

endmodule

// File: rtl/chaos_step_scheduler.sv
// Shares one chaos core between NREQ requesters: arbitrates, optionally
// reloads seeds, steps the core until DONE and hands the code word back.
// Optional feature macro: CHAOS_SCHED_TIMEOUT_EN (RUN timeout -> FAULT, sticky ERR).
module chaos_step_scheduler
    import chaos_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DONE_TMO = DONE_TMO_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ-1:0]     RESEED,
    input  logic [NREQ*32-1:0]  SHIFT_IN,
    output logic [NREQ-1:0]     GNT,
    output logic                VALID,
    input  logic [NREQ-1:0]     ACK,
    output logic [31:0]         CODE_OUT,
    output logic                CORE_STEP,
    output logic                CORE_RESET,
    output logic [31:0]         CORE_SHIFT,
    input  logic                CORE_DONE,
    input  logic [31:0]         CORE_CODE,
    output logic                ERR
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned SW = IW + 5;

    sched_state_t      state, state_n;
    logic [NREQ-1:0]   gnt_n;
    logic              valid_n;
    logic [31:0]       code_n;
    logic              step_n;
    logic              creset_n;
    logic [31:0]       shift_n;
    logic              force_seed, fs_n;
    logic              advance;
    logic              tmo_hit;
    logic [NREQ-1:0]   grant_c;
    logic [IW-1:0]     grant_idx_c;
    logic [SW-1:0]     slice_lsb;

    assign slice_lsb = {grant_idx_c, 5'b0};

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk         (CLK),
        .rst         (RESET),
        .req         (REQ),
        .advance     (advance),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

`ifdef CHAOS_SCHED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(DONE_TMO + 1);

    logic [CW-1:0] run_cnt, run_cnt_n;
    logic          err_q, err_n;

    assign tmo_hit = (run_cnt == CW'(DONE_TMO - 1));
    assign ERR     = err_q;

    // RUN step counter and sticky timeout flag.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            run_cnt <= run_cnt_n;
            err_q   <= err_n;
        end
    end
`else
    // DONE_TMO only matters when the timeout is built in.
    logic unused_tmo;
    assign unused_tmo = (DONE_TMO != 0);
    assign tmo_hit    = 1'b0;
    assign ERR        = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_n  = state;
        gnt_n    = GNT;
        valid_n  = VALID;
        code_n   = CODE_OUT;
        step_n   = 1'b0;
        creset_n = 1'b0;
        shift_n  = CORE_SHIFT;
        fs_n     = force_seed;
        advance  = 1'b0;
`ifdef CHAOS_SCHED_TIMEOUT_EN
        run_cnt_n = run_cnt;
        err_n     = err_q;
`endif
        case (state)
            IDLE: begin
                if (|REQ) state_n = ARB;
            end
            ARB: begin
                if (|grant_c) begin
                    advance = 1'b1;
                    gnt_n   = grant_c;
                    shift_n = SHIFT_IN[slice_lsb +: 32];
                    if (RESEED[grant_idx_c] || force_seed) begin
                        state_n  = SEED;
                        creset_n = 1'b1;
                        fs_n     = 1'b0;
                    end else begin
                        state_n = ARM;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            SEED: begin
                state_n = LOAD;
                step_n  = 1'b1;
            end
            LOAD: begin
                state_n = ARM;
            end
            ARM: begin
                state_n = RUN;
                step_n  = 1'b1;
`ifdef CHAOS_SCHED_TIMEOUT_EN
                run_cnt_n = '0;
`endif
            end
            RUN: begin
                if (CORE_DONE) begin
                    code_n  = CORE_CODE;
                    valid_n = 1'b1;
                    state_n = DELIVER;
                end else if (tmo_hit) begin
                    gnt_n   = '0;
                    fs_n    = 1'b1;
                    state_n = FAULT;
`ifdef CHAOS_SCHED_TIMEOUT_EN
                    err_n   = 1'b1;
`endif
                end else begin
                    step_n = 1'b1;
`ifdef CHAOS_SCHED_TIMEOUT_EN
                    run_cnt_n = run_cnt + CW'(1);
`endif
                end
            end
            DELIVER: begin
                if (|(ACK & GNT)) begin
                    valid_n = 1'b0;
                    gnt_n   = '0;
                    state_n = IDLE;
                end
            end
            FAULT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            GNT        <= '0;
            VALID      <= 1'b0;
            CODE_OUT   <= '0;
            CORE_STEP  <= 1'b0;
            CORE_RESET <= 1'b0;
            CORE_SHIFT <= SHIFT_DEFAULT;
            force_seed <= 1'b1;
        end else begin
            state      <= state_n;
            GNT        <= gnt_n;
            VALID      <= valid_n;
            CODE_OUT   <= code_n;
            CORE_STEP  <= step_n;
            CORE_RESET <= creset_n;
            CORE_SHIFT <= shift_n;
            force_seed <= fs_n;
        end
    end

endmodule

// File: doc/chaos_step_scheduler.md
CHAOS_STEP_SCHEDULER -- requirements
Module: chaos_step_scheduler

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one chaos core (2..8).
REQ-002 The block SHALL have parameter DONE_TMO, default 63, meaning the maximum number of RUN cycles to wait for CORE_DONE.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock.
REQ-004 The block SHALL have port RESET, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port REQ, input, NREQ bits: per-requester keystream-word request, level, held until granted.
REQ-006 The block SHALL have port RESEED, input, NREQ bits: per-requester flag, sampled with REQ, asking to reload seeds before stepping.
REQ-007 The block SHALL have port SHIFT_IN, input, NREQ*32 bits: per-requester IEEE-754 scale value, slice i owned by requester i.
REQ-008 The block SHALL have port GNT, output, NREQ bits: one-hot grant, held from arbitration until the ACK cycle.
REQ-009 The block SHALL have port VALID, output, 1 bit: CODE_OUT is valid for the granted requester.
REQ-010 The block SHALL have port ACK, input, NREQ bits: requester i consumes CODE_OUT; only the ACK bit of the granted requester is honoured.
REQ-011 The block SHALL have port CODE_OUT, output, 32 bits: {CODE_W, CODE_Z, CODE_Y, CODE_X} captured from the core.
REQ-012 The block SHALL have port CORE_STEP, output, 1 bit: the STEP input of the chaos core.
REQ-013 The block SHALL have port CORE_RESET, output, 1 bit: the seed-reload RESET input of the chaos core.
REQ-014 The block SHALL have port CORE_SHIFT, output, 32 bits: the SHIFT input of the chaos core.
REQ-015 The block SHALL have port CORE_DONE and CORE_CODE, inputs, 1 and 32 bits: DONE and the concatenated CODE bytes from the core.
REQ-016 The block SHALL have port ERR, output, 1 bit: sticky timeout flag.

Function
REQ-017 The state machine SHALL have the states IDLE, ARB, SEED, LOAD, ARM, RUN, DELIVER and FAULT.
REQ-018 IDLE SHALL go to ARB when REQ is non-zero; ARB SHALL issue a round-robin grant starting from the requester after the last one granted, and latch that requester's RESEED bit and SHIFT slice.
REQ-019 From ARB the state SHALL go to SEED if the latched RESEED bit is 1, otherwise to ARM.
REQ-020 SEED SHALL last 1 cycle with CORE_RESET=1 and CORE_STEP=0, then go to LOAD.
REQ-021 LOAD SHALL last 1 cycle with CORE_STEP=1 (the core latches CORE_SHIFT), then go to ARM.
REQ-022 ARM SHALL last 1 cycle with CORE_STEP=0 and CORE_RESET=0 (the core re-arms its counter), then go to RUN.
REQ-023 RUN SHALL hold CORE_STEP=1 until CORE_DONE=1, then capture CORE_CODE into CODE_OUT in that cycle, drop CORE_STEP on the next cycle and go to DELIVER.
REQ-024 DELIVER SHALL hold VALID=1 and GNT stable until ACK of the granted requester is 1; in the ACK cycle VALID and GNT SHALL fall and the state SHALL return to IDLE.
REQ-025 Latency from grant to VALID SHALL be 2 + core-DONE latency cycles without reseed, and 4 + core-DONE latency cycles with reseed.
REQ-026 The block SHALL hold CORE_SHIFT at the latched slice from ARB until the next ARB.
REQ-027 The block SHALL ignore a REQ drop by the granted requester after the grant; the transaction SHALL complete and wait for ACK.
REQ-028 The block SHALL ignore ACK bits of non-granted requesters and ACK while VALID=0.
REQ-029 With all REQ bits set, successive grants SHALL rotate 0,1,2,...,NREQ-1,0 with no requester granted twice before the others.
REQ-030 The round-robin pointer SHALL wrap from NREQ-1 to 0.

Reset
REQ-031 While RESET=1 the block SHALL asynchronously force state IDLE, GNT=0, VALID=0, CODE_OUT=0, CORE_STEP=0, CORE_RESET=0, CORE_SHIFT=32'h447a0000, ERR=0, and the round-robin pointer so that requester 0 is granted first.
REQ-032 Reset in any state SHALL abandon the transaction with no VALID pulse; the first grant after reset SHALL force a SEED pass regardless of RESEED.

Configuration
REQ-033 With CHAOS_SCHED_TIMEOUT_EN defined, a RUN counter SHALL count CORE_STEP cycles, and on reaching DONE_TMO without CORE_DONE the block SHALL set ERR, drive CORE_STEP=0 and enter FAULT.
REQ-034 With CHAOS_SCHED_TIMEOUT_EN defined, FAULT SHALL drop GNT and return to IDLE after 1 cycle, with the next grant forced through SEED.
REQ-035 Without CHAOS_SCHED_TIMEOUT_EN, the block SHALL remain in RUN indefinitely, FAULT SHALL be unreachable and ERR SHALL be tied to 0.

Structure
REQ-036 The package chaos_sched_pkg SHALL hold the state enum, the default SHIFT constant 32'h447a0000 and the DONE_TMO default.
REQ-037 The block SHALL contain one sub-module, rr_arbiter (NREQ-wide, pointer update on an advance strobe).

Verification
REQ-038 Single request: REQ=0001, RESEED=0, core DONE after 52 STEP cycles -> GNT=0001, CODE_OUT equals the core word, VALID rises 54 cycles after the grant and clears in the ACK cycle.
REQ-039 Reseed: REQ=0010, RESEED=0010, SHIFT slice 1=32'h42c80000 -> CORE_RESET pulses 1 cycle, CORE_SHIFT=32'h42c80000 in LOAD, then ARM and RUN follow.
REQ-040 Fairness: REQ=1111 held with immediate ACKs -> grant order 0,1,2,3,0,1.
REQ-041 Stray ACK: ACK=0100 while GNT=0001 in DELIVER -> VALID stays 1, GNT stays 0001.
REQ-042 Reset mid-RUN: assert RESET at RUN cycle 20 -> all outputs reach their reset values immediately and the next grant goes through SEED.
REQ-043 Timeout (CHAOS_SCHED_TIMEOUT_EN defined, core DONE stuck at 0) -> ERR=1 after 63 RUN cycles, CORE_STEP=0, IDLE after the FAULT cycle, and a pending REQ is served next through SEED.
